// File: rtl/hash_engine_arbiter_if.sv
// ---------------------------------------------------------------------------
// hash_engine_arbiter_if
//   Bundles the requester-facing and engine-facing signals of the hash engine
//   arbiter.
//   master modport : the arbiter itself (drives ack/rsp_*, busy, state and the
//                    engine controls; receives requests and engine results).
//   slave modport  : the environment (requesters plus the hash engine).
//   Signals:
//     req        requester request levels, one bit per requester
//     req_block  requester i block at [i*BLOCK_W +: BLOCK_W]
//     ack        one-hot, single-cycle response strobe
//     rsp_hash   hash for the acked requester (valid while ack != 0)
//     rsp_err    timeout flag (valid while ack != 0)
//     busy       arbiter not idle
//     state      one-hot FSM state (IDLE=1, ISSUE=2, WAIT=4, RESPOND=8)
//     hash_init  engine start pulse
//     valid      engine input valid
//     block_in   engine input block
//     hash       engine result
//     hash_ready engine result strobe
// ---------------------------------------------------------------------------
interface hash_engine_arbiter_if #(
    parameter int NREQ    = 4,
    parameter int BLOCK_W = 128,
    parameter int HASH_W  = 24
);
    logic [NREQ-1:0]         req;
    logic [NREQ*BLOCK_W-1:0] req_block;
    logic [NREQ-1:0]         ack;
    logic [HASH_W-1:0]       rsp_hash;
    logic                    rsp_err;
    logic                    busy;
    logic [3:0]              state;
    logic                    hash_init;
    logic                    valid;
    logic [BLOCK_W-1:0]      block_in;
    logic [HASH_W-1:0]       hash;
    logic                    hash_ready;

    modport master (
        input  req, req_block, hash, hash_ready,
        output ack, rsp_hash, rsp_err, busy, state, hash_init, valid, block_in
    );

    modport slave (
        output req, req_block, hash, hash_ready,
        input  ack, rsp_hash, rsp_err, busy, state, hash_init, valid, block_in
    );
endinterface

// File: rtl/hash_engine_arbiter.sv
// ---------------------------------------------------------------------------
// hash_engine_arbiter
//   Round-robin arbiter sharing a single hash engine between NREQ nonce-search
//   requesters. The winner's block is captured on the IDLE->ISSUE edge and
//   presented to the engine; the engine result (or a timeout error) is handed
//   back to that requester with a one-cycle one-hot ack.
//   Ports:
//     clk    rising-edge clock
//     reset  asynchronous active-high reset
//     bus    hash_engine_arbiter_if.master (requester and engine signals)
//   All outputs are registered.
// ---------------------------------------------------------------------------
module hash_engine_arbiter #(
    parameter int NREQ    = 4,
    parameter int BLOCK_W = 128,
    parameter int HASH_W  = 24,
    parameter int TIMEOUT = 255
) (
    input  logic                   clk,
    input  logic                   reset,
    hash_engine_arbiter_if.master  bus
);
    localparam int             IDX_W      = $clog2(NREQ);
    localparam logic [7:0]     TIMER_LAST = 8'(TIMEOUT - 1);
    localparam logic [IDX_W:0] NREQ_W     = (IDX_W + 1)'(NREQ);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NREQ - 1);

    typedef enum logic [3:0] {
        ST_IDLE    = 4'b0001,
        ST_ISSUE   = 4'b0010,
        ST_WAIT    = 4'b0100,
        ST_RESPOND = 4'b1000
    } state_t;

    state_t              state_reg;
    logic [IDX_W-1:0]    rr_ptr_reg;
    logic [IDX_W-1:0]    grant_id_reg;
    logic [7:0]          timer_reg;
    logic [NREQ-1:0]     ack_reg;
    logic [HASH_W-1:0]   rsp_hash_reg;
    logic                rsp_err_reg;
    logic                busy_reg;
    logic                hash_init_reg;
    logic                valid_reg;
    logic [BLOCK_W-1:0]  block_in_reg;

    // Unpacked view of the requester blocks and the round-robin candidate
    // order: cand_idx[k] is the requester checked k-th, i.e. (rr_ptr+k) mod NREQ.
    logic [BLOCK_W-1:0]  req_blocks [NREQ];
    logic [IDX_W-1:0]    cand_idx   [NREQ];

    generate
        for (genvar gi = 0; gi < NREQ; gi++) begin : g_cand
            logic [IDX_W:0] sum;
            assign req_blocks[gi] = bus.req_block[gi*BLOCK_W +: BLOCK_W];
            // rr_ptr < NREQ and gi < NREQ, so a single conditional subtract wraps.
            assign sum = {1'b0, rr_ptr_reg} + (IDX_W + 1)'(gi);
            assign cand_idx[gi] = (sum >= NREQ_W) ? IDX_W'(sum - NREQ_W) : IDX_W'(sum);
        end
    endgenerate

    // Lowest candidate position with a pending request wins; scanning from the
    // far end lets the nearest one overwrite.
    logic [IDX_W-1:0] winner_idx;
    always_comb begin
        winner_idx = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (bus.req[cand_idx[k]]) begin
                winner_idx = cand_idx[k];
            end
        end
    end

    logic [IDX_W-1:0] next_ptr;
    assign next_ptr = (grant_id_reg == LAST_IDX) ? '0 : grant_id_reg + 1'b1;

    logic [NREQ-1:0] grant_onehot;
    assign grant_onehot = {{(NREQ-1){1'b0}}, 1'b1} << grant_id_reg;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg     <= ST_IDLE;
            rr_ptr_reg    <= '0;
            grant_id_reg  <= '0;
            timer_reg     <= '0;
            ack_reg       <= '0;
            rsp_hash_reg  <= '0;
            rsp_err_reg   <= 1'b0;
            busy_reg      <= 1'b0;
            hash_init_reg <= 1'b0;
            valid_reg     <= 1'b0;
            block_in_reg  <= '0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (|bus.req) begin
                        grant_id_reg  <= winner_idx;
                        block_in_reg  <= req_blocks[winner_idx];
                        hash_init_reg <= 1'b1;
                        valid_reg     <= 1'b1;
                        busy_reg      <= 1'b1;
                        state_reg     <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    timer_reg     <= '0;
                    hash_init_reg <= 1'b0;
                    state_reg     <= ST_WAIT;
                end
                ST_WAIT: begin
                    // A result on the final timer cycle still counts as success.
                    if (bus.hash_ready) begin
                        rsp_hash_reg <= bus.hash;
                        rsp_err_reg  <= 1'b0;
                        ack_reg      <= grant_onehot;
                        valid_reg    <= 1'b0;
                        state_reg    <= ST_RESPOND;
                    end else if (timer_reg == TIMER_LAST) begin
                        rsp_hash_reg <= '0;
                        rsp_err_reg  <= 1'b1;
                        ack_reg      <= grant_onehot;
                        valid_reg    <= 1'b0;
                        state_reg    <= ST_RESPOND;
                    end else if (timer_reg != 8'hFF) begin
                        timer_reg <= timer_reg + 8'd1;
                    end
                end
                ST_RESPOND: begin
                    ack_reg    <= '0;
                    rr_ptr_reg <= next_ptr;
                    busy_reg   <= 1'b0;
                    state_reg  <= ST_IDLE;
                end
                default: begin
                    ack_reg       <= '0;
                    busy_reg      <= 1'b0;
                    hash_init_reg <= 1'b0;
                    valid_reg     <= 1'b0;
                    state_reg     <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.state     = state_reg;
    assign bus.ack       = ack_reg;
    assign bus.rsp_hash  = rsp_hash_reg;
    assign bus.rsp_err   = rsp_err_reg;
    assign bus.busy      = busy_reg;
    assign bus.hash_init = hash_init_reg;
    assign bus.valid     = valid_reg;
    assign bus.block_in  = block_in_reg;

endmodule
